// File: rtl/tile_walker_pkg.sv
// Shared types for the grid-locked player movement controller.
package poke_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    DOWN  = 2'd1,
    LEFT  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_QUERY,
    S_WAIT,
    S_MOVING
  } state_t;

  localparam int unsigned TILE_DEFAULT = 16;
  localparam int unsigned SCREEN_W     = 1024;
  localparam int unsigned SCREEN_H     = 768;

endpackage

// File: rtl/tile_walker_if.sv
// Walkability-map lookup port between the walker (master) and the level map (slave).
interface tile_walker_if;
  logic       query_valid_out;
  logic [5:0] query_tx_out;
  logic [5:0] query_ty_out;
  logic       walkable_in;

  modport master (
    output query_valid_out,
    output query_tx_out,
    output query_ty_out,
    input  walkable_in
  );

  modport slave (
    input  query_valid_out,
    input  query_tx_out,
    input  query_ty_out,
    output walkable_in
  );
endinterface

// File: rtl/tile_walker_dir_select.sv
// Button priority encoder (up > down > left > right) plus target-tile and map-edge check.
module dir_select
  import poke_pkg::*;
#(
  parameter int unsigned MAP_W = 64,
  parameter int unsigned MAP_H = 48
) (
  input  logic       up_in,
  input  logic       down_in,
  input  logic       left_in,
  input  logic       right_in,
  input  logic [5:0] tx_in,
  input  logic [5:0] ty_in,
  output logic       valid_out,
  output dir_t       dir_out,
  output logic [5:0] tgt_tx_out,
  output logic [5:0] tgt_ty_out,
  output logic       in_map_out
);

  always_comb begin
    valid_out  = up_in | down_in | left_in | right_in;
    dir_out    = RIGHT;
    tgt_tx_out = tx_in;
    tgt_ty_out = ty_in;
    in_map_out = 1'b0;
    if (up_in) begin
      dir_out    = UP;
      tgt_ty_out = ty_in - 6'd1;
      in_map_out = (ty_in != 6'd0);
    end else if (down_in) begin
      dir_out    = DOWN;
      tgt_ty_out = ty_in + 6'd1;
      in_map_out = (ty_in != 6'(MAP_H - 1));
    end else if (left_in) begin
      dir_out    = LEFT;
      tgt_tx_out = tx_in - 6'd1;
      in_map_out = (tx_in != 6'd0);
    end else if (right_in) begin
      dir_out    = RIGHT;
      tgt_tx_out = tx_in + 6'd1;
      in_map_out = (tx_in != 6'(MAP_W - 1));
    end
  end

endmodule

// File: rtl/tile_walker.sv
// Grid-locked player walker: samples buttons on the frame tick, queries the
// walkability map, then animates one tile at STEP pixels per frame.
module tile_walker
  import poke_pkg::*;
#(
  parameter int unsigned TILE      = TILE_DEFAULT,
  parameter int unsigned STEP      = 2,
  parameter int unsigned MAP_W     = 64,
  parameter int unsigned MAP_H     = 48,
  parameter int unsigned START_TX  = 4,
  parameter int unsigned START_TY  = 4,
  parameter int unsigned ROM_LAT   = 2,
  parameter int unsigned TICK_LINE = 768
) (
  input  logic               vclk_in,
  input  logic               rst_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               up_in,
  input  logic               down_in,
  input  logic               left_in,
  input  logic               right_in,
  tile_walker_if.master      map_if,
  output logic [10:0]        player_x_out,
  output logic [9:0]         player_y_out,
  output logic [1:0]         facing_out,
  output logic               moving_out
);

  localparam int unsigned OW = $clog2(TILE) + 1;
  localparam int unsigned CW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  if ((TILE % STEP) != 0) begin : g_bad_step
    $error("STEP must divide TILE");
  end
  if (ROM_LAT < 1) begin : g_bad_lat
    $error("ROM_LAT must be at least 1");
  end

  state_t        state_q, state_d;
  logic [5:0]    tx_q, tx_d, ty_q, ty_d;
  logic [5:0]    qtx_q, qtx_d, qty_q, qty_d;
  logic [10:0]   x_q, x_d;
  logic [9:0]    y_q, y_d;
  dir_t          facing_q, facing_d;
  logic [OW-1:0] off_q, off_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic       tick;
  logic       btn_valid;
  dir_t       btn_dir;
  logic [5:0] tgt_tx, tgt_ty;
  logic       tgt_in_map;

  assign tick = (hcount_in == 11'd0) && (vcount_in == 10'(TICK_LINE));

  dir_select #(
    .MAP_W(MAP_W),
    .MAP_H(MAP_H)
  ) u_dir_select (
    .up_in      (up_in),
    .down_in    (down_in),
    .left_in    (left_in),
    .right_in   (right_in),
    .tx_in      (tx_q),
    .ty_in      (ty_q),
    .valid_out  (btn_valid),
    .dir_out    (btn_dir),
    .tgt_tx_out (tgt_tx),
    .tgt_ty_out (tgt_ty),
    .in_map_out (tgt_in_map)
  );

  always_comb begin
    state_d  = state_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    qtx_d    = qtx_q;
    qty_d    = qty_q;
    x_d      = x_q;
    y_d      = y_q;
    facing_d = facing_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (tick && btn_valid) begin
          facing_d = btn_dir;
          if (tgt_in_map) begin
            qtx_d   = tgt_tx;
            qty_d   = tgt_ty;
            state_d = S_QUERY;
          end
        end
      end
      S_QUERY: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      // cnt_q reaches ROM_LAT-1 in the cycle ending ROM_LAT cycles after the strobe
      S_WAIT: begin
        if (cnt_q == CW'(ROM_LAT - 1)) begin
          if (map_if.walkable_in) begin
            tx_d    = qtx_q;
            ty_d    = qty_q;
            off_d   = '0;
            state_d = S_MOVING;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_MOVING: begin
        if (tick) begin
          unique case (facing_q)
            UP:    y_d = y_q - 10'(STEP);
            DOWN:  y_d = y_q + 10'(STEP);
            LEFT:  x_d = x_q - 11'(STEP);
            RIGHT: x_d = x_q + 11'(STEP);
          endcase
          off_d = off_q + OW'(STEP);
          if (off_d == OW'(TILE)) state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge vclk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      tx_q     <= 6'(START_TX);
      ty_q     <= 6'(START_TY);
      qtx_q    <= '0;
      qty_q    <= '0;
      x_q      <= 11'(START_TX * TILE);
      y_q      <= 10'(START_TY * TILE);
      facing_q <= DOWN;
      off_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      qtx_q    <= qtx_d;
      qty_q    <= qty_d;
      x_q      <= x_d;
      y_q      <= y_d;
      facing_q <= facing_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
    end
  end

  assign map_if.query_valid_out = (state_q == S_QUERY);
  assign map_if.query_tx_out    = qtx_q;
  assign map_if.query_ty_out    = qty_q;
  assign player_x_out           = x_q;
  assign player_y_out           = y_q;
  assign facing_out             = facing_q;
  assign moving_out             = (state_q == S_MOVING);

endmodule

// File: tb/tb_tile_walker.sv
// Directed bench for tile_walker: reset, walk, blocked query, map edge, priority, mid-move reset.
module tb_tile_walker;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic [10:0] hcount = 11'd5;
  logic [9:0]  vcount = 10'd0;
  logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;

  logic [10:0] x1, x0;
  logic [9:0]  y1, y0;
  logic [1:0]  f1, f0;
  logic        mv1, mv0;

  int errors = 0;
  int checks = 0;

  tile_walker_if mif1 ();
  tile_walker_if mif0 ();

  always #5 clk = ~clk;

  tile_walker #(
    .START_TX(4),
    .START_TY(4),
    .ROM_LAT (2)
  ) u_dut (
    .vclk_in      (clk),
    .rst_in       (rst),
    .hcount_in    (hcount),
    .vcount_in    (vcount),
    .up_in        (up),
    .down_in      (down),
    .left_in      (left),
    .right_in     (right),
    .map_if       (mif1),
    .player_x_out (x1),
    .player_y_out (y1),
    .facing_out   (f1),
    .moving_out   (mv1)
  );

  tile_walker #(
    .START_TX(0),
    .START_TY(4)
  ) u_dut_edge (
    .vclk_in      (clk),
    .rst_in       (rst),
    .hcount_in    (hcount),
    .vcount_in    (vcount),
    .up_in        (up),
    .down_in      (down),
    .left_in      (left),
    .right_in     (right),
    .map_if       (mif0),
    .player_x_out (x0),
    .player_y_out (y0),
    .facing_out   (f0),
    .moving_out   (mv0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One-cycle frame tick; returns at the falling edge just after the tick edge.
  task automatic tick_pulse();
    @(negedge clk);
    hcount = 11'd0;
    vcount = 10'd768;
    @(negedge clk);
    hcount = 11'd5;
    vcount = 10'd0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    mif1.walkable_in = 1'b0;
    mif0.walkable_in = 1'b0;

    // Reset state
    cyc(2);
    rst = 1'b0;
    chk("rst_x", 32'(x1), 32'd64);
    chk("rst_y", 32'(y1), 32'd64);
    chk("rst_facing", 32'(f1), 32'd1);
    chk("rst_moving", 32'(mv1), 32'd0);
    chk("rst_qvalid", 32'(mif1.query_valid_out), 32'd0);
    chk("rst_qtx", 32'(mif1.query_tx_out), 32'd0);
    chk("rst_qty", 32'(mif1.query_ty_out), 32'd0);
    chk("rst_edge_x", 32'(x0), 32'd0);

    // Walk right; walkable is high only in the cycle it must be sampled
    right = 1'b1;
    tick_pulse();
    chk("r_qvalid", 32'(mif1.query_valid_out), 32'd1);
    chk("r_qtx", 32'(mif1.query_tx_out), 32'd5);
    chk("r_qty", 32'(mif1.query_ty_out), 32'd4);
    chk("r_facing", 32'(f1), 32'd3);
    cyc(1);
    chk("r_qvalid_1cyc", 32'(mif1.query_valid_out), 32'd0);
    cyc(1);
    mif1.walkable_in = 1'b1;
    cyc(1);
    mif1.walkable_in = 1'b0;
    chk("r_moving_start", 32'(mv1), 32'd1);
    chk("r_x_before_tick", 32'(x1), 32'd64);
    right = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick_pulse();
      chk("r_x", 32'(x1), 32'(64 + 2 * k));
      chk("r_y", 32'(y1), 32'd64);
      chk("r_moving", 32'(mv1), (k < 8) ? 32'd1 : 32'd0);
    end
    chk("r_qtx_hold", 32'(mif1.query_tx_out), 32'd5);

    // Blocked upward move
    do_reset();
    up = 1'b1;
    tick_pulse();
    chk("b_qvalid", 32'(mif1.query_valid_out), 32'd1);
    chk("b_qtx", 32'(mif1.query_tx_out), 32'd4);
    chk("b_qty", 32'(mif1.query_ty_out), 32'd3);
    chk("b_facing", 32'(f1), 32'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(4);
      tick_pulse();
      chk("b_x", 32'(x1), 32'd64);
      chk("b_y", 32'(y1), 32'd64);
      chk("b_moving", 32'(mv1), 32'd0);
    end
    up = 1'b0;
    cyc(4);
    chk("b_moving_end", 32'(mv1), 32'd0);

    // Left edge of the map: no query at all
    do_reset();
    left = 1'b1;
    tick_pulse();
    chk("e_facing", 32'(f0), 32'd2);
    for (int k = 0; k < 5; k++) begin
      chk("e_qvalid", 32'(mif0.query_valid_out), 32'd0);
      cyc(1);
    end
    chk("e_x", 32'(x0), 32'd0);
    chk("e_moving", 32'(mv0), 32'd0);
    left = 1'b0;

    // Up beats right
    do_reset();
    up = 1'b1;
    right = 1'b1;
    mif1.walkable_in = 1'b1;
    tick_pulse();
    chk("p_facing", 32'(f1), 32'd0);
    chk("p_qvalid", 32'(mif1.query_valid_out), 32'd1);
    chk("p_qtx", 32'(mif1.query_tx_out), 32'd4);
    chk("p_qty", 32'(mif1.query_ty_out), 32'd3);
    up = 1'b0;
    right = 1'b0;
    cyc(3);
    mif1.walkable_in = 1'b0;
    chk("p_moving_start", 32'(mv1), 32'd1);
    for (int k = 1; k <= 8; k++) begin
      tick_pulse();
      chk("p_y", 32'(y1), 32'(64 - 2 * k));
      chk("p_x", 32'(x1), 32'd64);
    end
    chk("p_moving_end", 32'(mv1), 32'd0);

    // Reset in the middle of a move
    do_reset();
    right = 1'b1;
    mif1.walkable_in = 1'b1;
    tick_pulse();
    cyc(3);
    mif1.walkable_in = 1'b0;
    chk("m_moving", 32'(mv1), 32'd1);
    tick_pulse();
    tick_pulse();
    up = 1'b1;
    tick_pulse();
    chk("m_x", 32'(x1), 32'd70);
    chk("m_facing_ignored", 32'(f1), 32'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("m_rst_x", 32'(x1), 32'd64);
    chk("m_rst_moving", 32'(mv1), 32'd0);
    chk("m_rst_facing", 32'(f1), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("m_no_tick_qvalid", 32'(mif1.query_valid_out), 32'd0);
      cyc(1);
    end
    chk("m_no_tick_facing", 32'(f1), 32'd1);
    right = 1'b0;
    tick_pulse();
    chk("m_new_qvalid", 32'(mif1.query_valid_out), 32'd1);
    chk("m_new_facing", 32'(f1), 32'd0);
    chk("m_new_qtx", 32'(mif1.query_tx_out), 32'd4);
    chk("m_new_qty", 32'(mif1.query_ty_out), 32'd3);
    up = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tile_walker.md
Name: tile_walker

Overview:
- Grid-locked player movement controller that produces the player sprite position consumed by the top-level game renderer's sprite overlay.
- Samples the direction buttons once per frame and checks the target tile against the level walkability map through a query port.
- When the target tile is walkable, animates the player one tile at STEP pixels per frame.
- Position changes only at vertical blank, so the sprite never tears mid-frame.

Parameters:
- TILE, 16, tile edge in pixels; power of two.
- STEP, 2, pixels moved per frame; must divide TILE (elaboration-time assertion).
- MAP_W, 64, map width in tiles.
- MAP_H, 48, map height in tiles.
- START_TX, 4, reset tile column.
- START_TY, 4, reset tile row.
- ROM_LAT, 2, cycles from query_valid_out to walkable_in valid; must be ≥1.
- TICK_LINE, 768, vcount value at which the frame tick fires (first blank line).

Ports:
- vclk_in  input  1  65 MHz pixel clock.
- rst_in  input  1  synchronous, active-high reset.
- hcount_in  input  11  current pixel column.
- vcount_in  input  10  current pixel row.
- up_in / down_in / left_in / right_in  input  1 each  debounced direction buttons, level-sensitive.
- query_valid_out  output  1  one-cycle map lookup strobe.
- query_tx_out  output  6  target tile column.
- query_ty_out  output  6  target tile row.
- walkable_in  input  1  map answer; sampled exactly ROM_LAT cycles after the strobe.
- player_x_out  output  11  sprite top-left x in pixels.
- player_y_out  output  10  sprite top-left y in pixels.
- facing_out  output  2  dir_t: UP=0, DOWN=1, LEFT=2, RIGHT=3.
- moving_out  output  1  high while a step animation is in progress.

Behaviour:
- Clocking: one clock, vclk_in. Reset is synchronous and active-high on rst_in. Reset is sampled every cycle and overrides all state, including mid-move and mid-query.
- Reset values:
  - player_x_out = START_TX*TILE, player_y_out = START_TY*TILE.
  - Tile registers = START_TX/START_TY.
  - facing_out = DOWN, moving_out = 0.
  - query_valid_out = 0, query_tx_out = 0, query_ty_out = 0.
  - FSM = IDLE, offset = 0.
- Frame tick: one cycle when hcount_in==0 && vcount_in==TICK_LINE. All position, facing and button decisions happen only on a tick.
- FSM states: IDLE, QUERY, WAIT, MOVING.
- IDLE, on a tick:
  - No button pressed: remain in IDLE, no change.
  - Button pressed: priority up > down > left > right. facing_out updates to the chosen direction on the next cycle, even if the move is later blocked.
  - Target computed as tile ±1 on one axis.
  - Target off map (tx==0 going left, tx==MAP_W-1 going right, ty==0 going up, ty==MAP_H-1 going down): blocked, no query issued, remain in IDLE.
  - Otherwise go to QUERY.
- QUERY:
  - query_valid_out = 1 for exactly this one cycle.
  - query_tx_out/query_ty_out = target; these hold their value until the next query.
  - Next state WAIT, with a latency counter cleared.
- WAIT:
  - Counter counts to ROM_LAT, then walkable_in is sampled.
  - walkable_in = 1: tile registers take the target, offset = 0, go to MOVING.
  - walkable_in = 0: return to IDLE.
  - A tick arriving in QUERY or WAIT is ignored. The button is re-sampled on the next tick.
- MOVING:
  - moving_out = 1.
  - On each tick, the pixel coordinate on the facing axis moves ±STEP and offset += STEP.
  - When offset reaches TILE, go to IDLE and drop moving_out in the same cycle. The pixel position then equals tile*TILE exactly.
  - Buttons are ignored during MOVING.
  - A new move can start no earlier than the following tick, so there are TILE/STEP ticks per tile.
- Arithmetic: pixel coordinates are unsigned and never go out of range, because bounds are checked before the move. tx*TILE always fits in 11 bits and ty*TILE in 10 bits.
- Latency:
  - Button held at tick T: first pixel change at tick T+1.
  - Arrival at tick T+TILE/STEP.

Decomposition:
- Package poke_pkg: dir_t enum, fsm state enum, TILE_DEFAULT, SCREEN_W=1024, SCREEN_H=768.
- One natural sub-module, dir_select: a priority encoder from the four buttons to {valid, dir_t}, plus a target-tile/bounds calculator.
- The FSM, counters and position registers stay in tile_walker.

Test Plan:
- Reset: assert rst_in for 2 cycles → x=64, y=64, facing=DOWN (1), moving=0, query_valid=0.
- Hold right_in, walkable_in=1 → one-cycle query (tx=5, ty=4); walkable sampled 2 cycles later; x goes 66, 68, … 80 on 8 successive ticks; moving_out falls on the 8th; y stays 64.
- Hold up_in, walkable_in=0 → query (4,3); facing=UP (0); x and y unchanged; moving_out stays 0 across 3 ticks.
- START_TX=0, hold left_in → facing=LEFT (2); query_valid_out never asserts; x stays 0.
- up_in and right_in together with walkable=1 → UP chosen; query (4,3); y goes 62 … 48 over 8 ticks.
- rst_in asserted mid-move (after 3 ticks, x=70) → next cycle x=64, moving=0, FSM IDLE; presses during the move are ignored, and after reset a fresh press is accepted only on a tick.
